rr_arb8_ctrl: RTL and testbench

Round-robin arbiter that shares one downstream resource among eight requesters and reports the winner both one-hot and as a 3-bit binary index, the same index coding as our 8:3 encoder. It sits between eight request sources and the shared datapath, registers every grant, and holds it until the owner signals completion. An optional hold-timeout watchdog reclaims the resource from a stuck owner.

---
 rtl/rr_arb8_ctrl.sv | 138 +++++++++++++
 tb/tb_rr_arb8_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb8_ctrl.sv
// rr_arb8_ctrl - eight-way round-robin arbiter with registered grant hold.
//
// Shares one downstream resource among eight requesters. A grant is
// registered and held until the owner signals done or withdraws its
// request. On release, the next winner is chosen in the same cycle, so
// there is no idle cycle between owners. The search order rotates so that
// the releasing owner has the lowest priority.
//
// Optional feature macro: ARB_HOLD_TIMEOUT_EN
//   When this macro is defined, a hold counter force-releases an owner after
//   MAX_HOLD cycles and pulses `timeout` for one cycle. When it is not
//   defined, `timeout` is tied to 0 and MAX_HOLD is only range-checked.
//
// Parameters:
//   MAX_HOLD  grant hold limit in cycles (2..255), timeout build only
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   req      in   8  level request vector, bit i = requester i
//   done     in   1  owner finished (ignored while no grant is active)
//   gnt      out  8  one-hot grant, zero when idle
//   gnt_idx  out  3  binary index of the granted requester, 0 when idle
//   gnt_vld  out  1  grant active
//   timeout  out  1  one-cycle pulse on a forced release
module rr_arb8_ctrl #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [2:0] last, last_nxt;
    logic [7:0] gnt_nxt;
    logic [2:0] idx_nxt;
    logic [3:0] pick;
    logic       found;
    logic [2:0] winner;
    logic       force_rel;
    logic       release_c;
    logic       arb_c;

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
            $error("rr_arb8_ctrl: MAX_HOLD must be in 2..255");
        end
    endgenerate

    // Returns {found, index} of the first set bit in the order ptr+1 .. ptr+8.
    // The loop walks from lowest to highest priority so the last hit wins.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] cand;
        res = 4'd0;
        for (int k = 8; k >= 1; k--) begin
            cand = ptr + 3'(k);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    assign pick   = rr_pick(req, last);
    assign found  = pick[3];
    assign winner = pick[2:0];

`ifdef ARB_HOLD_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // A forced release happens only when nothing else would release this cycle.
    assign force_rel = (state == GRANT) && (hold_cnt == 8'(MAX_HOLD - 1))
                       && !done && req[gnt_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_rel;
            if (arb_c || state != GRANT)
                hold_cnt <= 8'd0;
            else if (hold_cnt != 8'hFF)
                hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    // In GRANT, `last` equals the current owner, so searching after `last`
    // starts after the releasing owner; it wins only if it is the sole requester.
    assign release_c = (state == GRANT) && (done || !req[gnt_idx] || force_rel);
    assign arb_c     = (state == IDLE) || release_c;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        last_nxt  = last;
        if (arb_c) begin
            if (found) begin
                state_nxt = GRANT;
                gnt_nxt   = 8'b1 << winner;
                idx_nxt   = winner;
                last_nxt  = winner;
            end else begin
                state_nxt = IDLE;
                gnt_nxt   = 8'h00;
                idx_nxt   = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= 8'h00;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
            last    <= 3'd7;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            gnt_vld <= (state_nxt == GRANT);
            last    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Testbench for rr_arb8_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_rr_arb8_ctrl;

    localparam int MAXH = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    bit m_vld;
    int m_idx;
    int m_last;
    int m_cnt;
    bit m_to;

    rr_arb8_ctrl #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vld  = 1'b0;
        m_idx  = 0;
        m_last = 7;
        m_cnt  = 0;
        m_to   = 1'b0;
    endtask

    // One clock edge of the arbiter as described behaviourally.
    task automatic model_step();
        bit fire, rel, hit;
        fire = TO_EN && m_vld && (m_cnt == MAXH - 1) && !done && req[m_idx];
        rel  = m_vld && (done || !req[m_idx] || fire);
        if (!m_vld || rel) begin
            hit = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                int i;
                i = (m_last + k) % 8;
                if (!hit && req[i]) begin
                    hit    = 1'b1;
                    m_vld  = 1'b1;
                    m_idx  = i;
                    m_last = i;
                    m_cnt  = 0;
                end
            end
            if (!hit) begin
                m_vld = 1'b0;
                m_idx = 0;
            end
        end else if (m_cnt < 255) begin
            m_cnt++;
        end
        m_to = fire;
    endtask

    // Advance one edge; returns 1 time unit after it so inputs change off-edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("gnt",     32'(gnt),     m_vld ? (32'd1 << m_idx) : 32'd0);
            chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
            chk("gnt_vld", 32'(gnt_vld), 32'(m_vld));
            chk("timeout", 32'(timeout), 32'(m_to));
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        model_reset();
        #2;
        chk("rst_gnt",     32'(gnt),     32'h00);
        chk("rst_gnt_idx", 32'(gnt_idx), 32'h0);
        chk("rst_gnt_vld", 32'(gnt_vld), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        #10;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset priority and full rotation with done every cycle
        tick();
        chk("first_gnt", 32'(gnt), 32'h01);
        chk("first_idx", 32'(gnt_idx), 32'h0);
        done = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("rot_idx", 32'(gnt_idx), 32'(k % 8));
            chk("rot_vld", 32'(gnt_vld), 32'h1);
        end

        // Sparse rotation
        req = 8'b0000_0100;
        tick();
        chk("sparse_setup", 32'(gnt_idx), 32'd2);
        req = 8'b1000_0100;
        tick();
        chk("sparse_7", 32'(gnt_idx), 32'd7);
        tick();
        chk("sparse_2", 32'(gnt_idx), 32'd2);
        req = 8'h00;
        tick();
        chk("sparse_idle_vld", 32'(gnt_vld), 32'h0);
        chk("sparse_idle_idx", 32'(gnt_idx), 32'h0);

        // Withdrawal
        done = 1'b0;
        req  = 8'h08;
        tick();
        chk("wd_grant3", 32'(gnt_idx), 32'd3);
        tick();
        chk("wd_hold3", 32'(gnt), 32'h08);
        req = 8'h00;
        tick();
        chk("wd_idle", 32'(gnt_vld), 32'h0);
        req = 8'h08;
        tick();
        req = 8'h20;
        tick();
        chk("wd_b2b5", 32'(gnt_idx), 32'd5);
        chk("wd_b2b5_vld", 32'(gnt_vld), 32'h1);

        // Sole requester re-grant after done
        req = 8'h10;
        tick();
        chk("sole_4", 32'(gnt_idx), 32'd4);
        done = 1'b1;
        tick();
        chk("sole_regrant", 32'(gnt_idx), 32'd4);
        chk("sole_vld", 32'(gnt_vld), 32'h1);
        done = 1'b0;
        tick();
        tick();
        chk("sole_hold", 32'(gnt), 32'h10);

        // Mid-grant asynchronous reset
        req = 8'h40;
        tick();
        chk("mr_grant6", 32'(gnt_idx), 32'd6);
        #3;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mr_gnt",     32'(gnt),     32'h00);
        chk("mr_gnt_idx", 32'(gnt_idx), 32'h0);
        chk("mr_gnt_vld", 32'(gnt_vld), 32'h0);
        chk("mr_timeout", 32'(timeout), 32'h0);
        model_reset();
        #3;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();
        chk("mr_regrant6", 32'(gnt_idx), 32'd6);

        // Hold timeout (or indefinite hold without the feature)
        req = 8'h06;
        tick();
        chk("to_grant1", 32'(gnt_idx), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_hold1", 32'(gnt_idx), 32'd1);
            chk("to_quiet", 32'(timeout), 32'h0);
        end
        tick();
        chk("to_idx",   32'(gnt_idx), TO_EN ? 32'd2 : 32'd1);
        chk("to_pulse", 32'(timeout), TO_EN ? 32'h1 : 32'h0);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'h0);

        // Randomized traffic checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: req = 8'($urandom);
                1: req = 8'($urandom) & 8'($urandom);
                2: req = 8'(1 << $urandom_range(0, 7));
                default: req = req;
            endcase
            done = ($urandom_range(0, 3) == 0);
            tick();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
